// File: rtl/ssd_scanner.sv
// Common-anode 4-digit seven-segment scanner: time-multiplexes four hex digits
// onto active-low anode/cathode pins. Optional macro: SSD_GHOST_BLANK_EN.
module ssd_scanner #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             slot_end;
  logic             cur_en;
  logic [3:0]       cur_val;
  logic [3:0]       cur_onehot;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // NOTE: every output of this block gets a default before any branch so no latch is inferred.
  always_comb begin
    slot_end = (div_q == DIV_LAST);
    div_d    = slot_end ? '0 : div_q + 1'b1;
    sel_d    = slot_end ? sel_q + 2'd1 : sel_q;

    cur_en  = digit0_en_i;
    cur_val = digit0_i;
    case (sel_q)
      2'd1: begin cur_en = digit1_en_i; cur_val = digit1_i; end
      2'd2: begin cur_en = digit2_en_i; cur_val = digit2_i; end
      2'd3: begin cur_en = digit3_en_i; cur_val = digit3_i; end
      default: begin cur_en = digit0_en_i; cur_val = digit0_i; end
    endcase

    cur_onehot = 4'b0001 << sel_q;
    anode_d    = cur_en ? ~cur_onehot : 4'b1111;
`ifdef SSD_GHOST_BLANK_EN
    // First cycle of each slot stays dark so the previous digit cannot ghost.
    if (div_q == '0) anode_d = 4'b1111;
`endif
    seg_d = hex_decode(cur_val);
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous and overrides the slot boundary.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= '0;
      sel_q   <= 2'd0;
      anode_q <= 4'b1111;
      seg_q   <= 7'h7F;
    end else begin
      div_q   <= div_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode_o    = anode_q;
  assign segments_o = seg_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// Directed bench for ssd_scanner with SCAN_DIV=4; honours SSD_GHOST_BLANK_EN.
module tb_ssd_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = 4'b1111;
  logic [3:0] dv [4];
  logic [3:0] anode;
  logic [6:0] segs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ssd_scanner #(.SCAN_DIV(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .digit0_en_i (en[0]),
    .digit1_en_i (en[1]),
    .digit2_en_i (en[2]),
    .digit3_en_i (en[3]),
    .digit0_i    (dv[0]),
    .digit1_i    (dv[1]),
    .digit2_i    (dv[2]),
    .digit3_i    (dv[3]),
    .anode_o     (anode),
    .segments_o  (segs)
  );

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Slot shown on the pins at cycle c (1 = first edge after reset release).
  function automatic int slot_of(input int c);
    return ((c - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_anode(input int c, input logic [3:0] e);
    int s;
    logic [3:0] onehot;
    s = slot_of(c);
    onehot = 4'b0001 << s;
`ifdef SSD_GHOST_BLANK_EN
    if ((c - 1) % 4 == 0) return 4'b1111;
`endif
    if (!e[s]) return 4'b1111;
    return ~onehot;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    en = 4'b1111;
    dv[0] = 4'h0; dv[1] = 4'h1; dv[2] = 4'h2; dv[3] = 4'h3;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (anode !== 4'b1111 || segs !== 7'h7F) begin
        errors++;
        $display("FAIL reset_hold[%0d]: anode=%b segs=%h, want 1111/7f", i, anode, segs);
      end
    end
    rst_n = 1'b1;
    cyc = 0;
    step();
    checks++;
    if (anode !== exp_anode(1, en) || segs !== 7'h40) begin
      errors++;
      $display("FAIL reset_release: anode=%b segs=%h, want %b/40", anode, segs, exp_anode(1, en));
    end
    // Run into slot 2 and pulse reset mid-slot.
    while (cyc < 10) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (anode !== 4'b1111 || segs !== 7'h7F) begin
      errors++;
      $display("FAIL reset_midslot: anode=%b segs=%h, want 1111/7f", anode, segs);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (anode !== exp_anode(cyc, en) || segs !== 7'h40) begin
        errors++;
        $display("FAIL reset_restart[%0d]: anode=%b segs=%h, want %b/40",
                 cyc, anode, segs, exp_anode(cyc, en));
      end
    end
  endtask

  task automatic test_scan_order();
    logic [6:0] want_seg;
    en = 4'b1111;
    dv[0] = 4'h3; dv[1] = 4'h2; dv[2] = 4'h1; dv[3] = 4'h0;
    release_reset();
    for (int i = 0; i < 32; i++) begin
      step();
      want_seg = font(dv[slot_of(cyc)]);
      checks++;
      if (anode !== exp_anode(cyc, en) || segs !== want_seg) begin
        errors++;
        $display("FAIL scan_order[%0d]: anode=%b segs=%h, want %b/%h",
                 cyc, anode, segs, exp_anode(cyc, en), want_seg);
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [6:0] want_seg;
    en = 4'b0001;
    dv[1] = 4'h5; dv[2] = 4'hA; dv[3] = 4'hE;
    dv[0] = 4'h0;
    release_reset();
    for (int v = 0; v < 16; v++) begin
      dv[0] = 4'(v);
      for (int i = 0; i < 16; i++) begin
        step();
        want_seg = font(dv[slot_of(cyc)]);
        checks++;
        if (anode !== exp_anode(cyc, en) || segs !== want_seg) begin
          errors++;
          $display("FAIL decode_sweep[v=%h c=%0d]: anode=%b segs=%h, want %b/%h",
                   v, cyc, anode, segs, exp_anode(cyc, en), want_seg);
        end
      end
    end
  endtask

  task automatic test_disable();
    en = 4'b1101;
    dv[0] = 4'h7; dv[1] = 4'h8; dv[2] = 4'h9; dv[3] = 4'hC;
    release_reset();
    while (cyc < 6) begin
      step();
      checks++;
      if (anode !== exp_anode(cyc, en)) begin
        errors++;
        $display("FAIL disable_slot1[%0d]: anode=%b want %b", cyc, anode, exp_anode(cyc, en));
      end
    end
    checks++;
    if (anode !== 4'b1111) begin
      errors++;
      $display("FAIL disable_dark: anode=%b want 1111", anode);
    end
    en[1] = 1'b1;
    step();
    checks++;
    if (anode !== 4'b1101 || segs !== 7'h00) begin
      errors++;
      $display("FAIL disable_toggle: anode=%b segs=%h, want 1101/00", anode, segs);
    end
    en = 4'b0000;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (anode !== 4'b1111 || segs !== font(dv[slot_of(cyc)])) begin
        errors++;
        $display("FAIL all_disabled[%0d]: anode=%b segs=%h, want 1111/%h",
                 cyc, anode, segs, font(dv[slot_of(cyc)]));
      end
    end
  endtask

  task automatic test_blanking();
    int lit [4];
    int want_lit;
    logic [3:0] onehot;
`ifdef SSD_GHOST_BLANK_EN
    want_lit = 3;
`else
    want_lit = 4;
`endif
    en = 4'b1111;
    release_reset();
    for (int s = 0; s < 4; s++) lit[s] = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      onehot = 4'b0001 << slot_of(cyc);
      if (anode === ~onehot) lit[slot_of(cyc)]++;
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (lit[s] != want_lit) begin
        errors++;
        $display("FAIL blanking_slot%0d: lit=%0d cycles, want %0d", s, lit[s], want_lit);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dv[i] = 4'h0;
    test_reset();
    test_scan_order();
    test_decode_sweep();
    test_disable();
    test_blanking();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
